// File: rtl/switch_pkg.sv
// Shared types and constants for the board switch conditioning blocks.
package switch_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } db_state_t;

  // 10 ms of stable samples at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for an asynchronous board pin; plain shift chain, async active-low reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic synced
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], pin};
    end
  end

  assign synced = s[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the slide switch; emits level plus rise/fall strobes.
// Optional push-on/push-off output enabled by defining SWITCH_DEBOUNCE_TOGGLE_EN.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic board_clk,
  input  logic board_rst_n,
  input  logic switch_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_toggle
);

  // Out-of-range stage counts are pulled back into the supported window.
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sync_out;
  db_state_t       state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES (SYNC_N)
  ) u_sync (
    .clk    (board_clk),
    .rst_n  (board_rst_n),
    .pin    (switch_raw),
    .synced (sync_out)
  );

  // Qualification fires on the DEBOUNCE_CYCLES-th consecutive opposite sample,
  // so the counter never needs to go past CNT_LAST.
  always_ff @(posedge board_clk or negedge board_rst_n) begin
    if (!board_rst_n) begin
      state    <= STABLE_LOW;
      cnt      <= '0;
      sw_level <= 1'b0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
    end else begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (sync_out) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync_out) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= STABLE_HIGH;
            sw_level <= 1'b1;
            sw_rise  <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!sync_out) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync_out) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= STABLE_LOW;
            sw_level <= 1'b0;
            sw_fall  <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  always_ff @(posedge board_clk or negedge board_rst_n) begin
    if (!board_rst_n) begin
      sw_toggle <= 1'b0;
    end else if (sw_rise) begin
      sw_toggle <= ~sw_toggle;
    end
  end
`else
  assign sw_toggle = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce: directed scenarios plus randomized pin activity.
module tb_switch_debounce;

  localparam int S = 2;
  localparam int D = 4;

  logic board_clk;
  logic board_rst_n;
  logic switch_raw;
  logic sw_level;
  logic sw_rise;
  logic sw_fall;
  logic sw_toggle;

  int n_checks;
  int n_errors;

  // Reference model: pin history delayed by the synchroniser, then a run-length rule.
  logic pipe [S];
  int   run;
  logic m_lvl, m_rise, m_fall, m_tog;

  switch_debounce #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .board_clk   (board_clk),
    .board_rst_n (board_rst_n),
    .switch_raw  (switch_raw),
    .sw_level    (sw_level),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .sw_toggle   (sw_toggle)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) pipe[i] = 1'b0;
    run    = 0;
    m_lvl  = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_tog  = 1'b0;
  endtask

  task automatic model_step();
    logic seen;
    seen = pipe[S-1];
    for (int i = S-1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = switch_raw;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    if (m_rise) m_tog = ~m_tog;
`endif
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (seen != m_lvl) begin
      run++;
      if (run == D) begin
        m_lvl  = seen;
        m_rise = seen;
        m_fall = ~seen;
        run    = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".level"},  sw_level,  m_lvl);
    check_eq({tag, ".rise"},   sw_rise,   m_rise);
    check_eq({tag, ".fall"},   sw_fall,   m_fall);
    check_eq({tag, ".toggle"}, sw_toggle, m_tog);
    check_eq({tag, ".excl"},   sw_rise & sw_fall, 1'b0);
  endtask

  // Drive the pin for one cycle, advance the model at the edge, check #1 later.
  task automatic cycle(input logic pin, input string tag);
    switch_raw = pin;
    @(posedge board_clk);
    if (board_rst_n) model_step();
    else model_reset();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input logic pin);
    board_rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_async");
    for (int i = 0; i < 3; i++) cycle(pin, "rst_hold");
    board_rst_n = 1'b1;
  endtask

  task automatic settle(input logic pin);
    for (int i = 0; i < S + D + 2; i++) cycle(pin, "settle");
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    switch_raw  = 1'b1;
    board_rst_n = 1'b0;
    model_reset();
    #2;

    // Reset with pin high, then normal rise after release.
    do_reset(1'b1);
    for (int e = 0; e < 8; e++) begin
      cycle(1'b1, "t1");
      check_eq("t1_rise", sw_rise, (e == 5));
      check_eq("t1_level", sw_level, (e >= 5));
      check_eq("t1_fall", sw_fall, 1'b0);
    end

    // Clean rise.
    settle(1'b0);
    for (int e = 0; e < 8; e++) begin
      cycle(1'b1, "t2");
      check_eq("t2_rise", sw_rise, (e == 5));
      check_eq("t2_level", sw_level, (e >= 5));
    end

    // Bounce rejection.
    settle(1'b0);
    begin
      logic [5:0] pat;
      pat = 6'b011011;
      for (int i = 0; i < 12; i++) begin
        cycle((i < 6) ? pat[i] : 1'b0, "t3");
        check_eq("t3_level", sw_level, 1'b0);
        check_eq("t3_rise", sw_rise, 1'b0);
        check_eq("t3_fall", sw_fall, 1'b0);
      end
    end

    // Clean fall after stable high.
    settle(1'b1);
    for (int e = 0; e < 8; e++) begin
      cycle(1'b0, "t4");
      check_eq("t4_fall", sw_fall, (e == 5));
      check_eq("t4_level", sw_level, (e < 5));
      check_eq("t4_rise", sw_rise, 1'b0);
    end

    // Reset mid-wait, then full latency restart.
    settle(1'b0);
    for (int e = 0; e < 4; e++) cycle(1'b1, "t5_pre");
    do_reset(1'b1);
    for (int e = 0; e < 8; e++) begin
      cycle(1'b1, "t5");
      check_eq("t5_rise", sw_rise, (e == 5));
      check_eq("t5_level", sw_level, (e >= 5));
    end

    // Reset while high must clear the level without a clock edge.
    board_rst_n = 1'b0;
    #1;
    check_eq("t5_async_level", sw_level, 1'b0);
    model_reset();
    @(posedge board_clk);
    #1;
    board_rst_n = 1'b1;

    // Toggle behaviour over three press/release cycles.
    do_reset(1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, "t6_press");
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      check_eq("t6_toggle", sw_toggle, (p % 2 == 0));
`else
      check_eq("t6_toggle", sw_toggle, 1'b0);
`endif
      for (int i = 0; i < 10; i++) cycle(1'b0, "t6_release");
    end

    // Randomized runs with occasional resets.
    for (int k = 0; k < 150; k++) begin
      logic v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) cycle(v, "rand");
      if ($urandom_range(0, 29) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
